// File: rtl/regfile_dumper.sv
// Walks a register address range through one regfile read port and streams
// each captured word as an address/data beat over a valid/ready handshake.
module regfile_dumper #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic [ADDR_W-1:0] FirstAddr,
  input  logic [ADDR_W-1:0] LastAddr,
  input  logic              Abort,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [DATA_W-1:0] RdData,
  output logic              OutValid,
  input  logic              OutReady,
  output logic [ADDR_W-1:0] OutAddr,
  output logic [DATA_W-1:0] OutData,
  output logic              Busy,
  output logic              Done
);

  // Handshake: a beat transfers on a rising edge where OutValid && OutReady;
  // while OutValid is high, OutAddr/OutData stay frozen until that transfer.

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_READ = 2'd1;
  localparam logic [1:0] ST_SEND = 2'd2;
  localparam logic [1:0] ST_FIN  = 2'd3;

  localparam logic [ADDR_W-1:0] TOP_ADDR = ADDR_W'(NUM_REGS - 1);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W-1:0] last_q, last_d;
  logic              out_valid_q, out_valid_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              at_end;

  // The top-address guard keeps ptr from wrapping even if last were misprogrammed.
  assign at_end = (ptr_q == last_q) || (ptr_q == TOP_ADDR);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    last_d      = last_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_data_d  = out_data_q;
    case (state_q)
      ST_IDLE: begin
        if (Start) begin
          if (FirstAddr <= LastAddr) begin
            ptr_d   = FirstAddr;
            last_d  = LastAddr;
            state_d = ST_READ;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_READ: begin
        if (Abort) begin
          state_d = ST_IDLE;
        end else begin
          out_data_d  = RdData;
          out_addr_d  = ptr_q;
          out_valid_d = 1'b1;
          state_d     = ST_SEND;
        end
      end
      ST_SEND: begin
        if (Abort) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else if (OutReady) begin
          out_valid_d = 1'b0;
          if (at_end) begin
            state_d = ST_FIN;
          end else begin
            ptr_d   = ptr_q + ONE;
            state_d = ST_READ;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q     <= ST_IDLE;
      ptr_q       <= '0;
      last_q      <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      last_q      <= last_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_data_q  <= out_data_d;
    end
  end

  assign RdAddr   = (state_q != ST_IDLE) ? ptr_q : '0;
  assign OutValid = out_valid_q;
  assign OutAddr  = out_addr_q;
  assign OutData  = out_data_q;
  assign Busy     = (state_q != ST_IDLE);
  assign Done     = (state_q == ST_FIN);

endmodule
